clic_gateway: RTL and testbench
===============================

# clic_gateway

Per-source interrupt gateway directly upstream of the CLIC priority arbiter. It synchronizes raw interrupt lines, applies per-source trigger type and polarity, and holds the interrupt-pending (IP) state. It produces the `ip`/`le` vectors the arbiter consumes. It clears edge-triggered pending bits on the arbiter's claim pulse or on software writes to the IP register.

## Interface
- `N_SOURCE`, 256, number of interrupt sources (≥2).
- `SyncStages`, 2, synchronizer depth on raw lines; 0 bypasses (sources already in `clk_i` domain).
- `SrcWidth`, $clog2(N_SOURCE), derived; do not override.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `intr_src_i`  in  N_SOURCE  raw interrupt lines, possibly asynchronous.
- `trig_i`  in  [N_SOURCE][2]  per-source trigger config. Bit0 = 1 means edge-triggered; bit1 = 1 means negative polarity (falling edge / active-low).
- `ip_we_i`  in  1  software write strobe for one IP bit.
- `ip_widx_i`  in  SrcWidth  source index of the write.
- `ip_wdata_i`  in  1  value written.
- `claim_i`  in  N_SOURCE  one-hot claim pulse from the arbiter.
- `ip_o`  out  N_SOURCE  pending vector to the arbiter; also the IP register read value.
- `le_o`  out  N_SOURCE  edge-enable to the arbiter; equals `trig_i[n][0]`.

## Operation
- Synchronizer:
  - `s[n]` is the last stage of a `SyncStages`-deep flop chain on `intr_src_i[n]`; every stage resets to 0.
  - `prev_q[n]` registers `s[n]`; resets to 0.
- Active level: `act[n] = s[n] ^ trig_i[n][1]`.
- Edge event:
  - Positive polarity: `s & ~prev_q`.
  - Negative polarity: `~s & prev_q`.
  - Raw-value tracking with reset 0 means an idle-high line produces one rising event after reset and never a falling event.
- Level mode (`trig_i[n][0]=0`):
  - Each cycle, `ip_q[n] <= act[n]`.
  - Software writes and `claim_i[n]` are ignored.
- Edge mode (`trig_i[n][0]=1`), next-state priority, highest first:
  1. Edge event → set.
  2. Software write with `ip_wdata_i=1` → set.
  3. Software write with `ip_wdata_i=0`, or `claim_i[n]` → clear.
  4. Otherwise hold.
- Simultaneous event and claim: the event wins, so no edge is lost. The arbiter sees the source pending again.
- Trigger-type change does not alter `ip_q` directly:
  - Level→edge: the last level value is held until cleared.
  - Edge→level: `ip_q` follows `act` from the next cycle.
- A software write to an index ≥ `N_SOURCE` is ignored.
- Only one software write per cycle. Claims may be multi-hot; each bit acts independently.
- `ip_o = ip_q`. `le_o` is combinational from `trig_i`.

## Timing
- Reset: all synchronizer stages, `prev_q` and `ip_q` are 0, so `ip_o = 0`. `le_o` follows `trig_i` during reset.
- Raw input change → `ip_o` change: `SyncStages + 1` cycles. With `SyncStages = 0`, 1 cycle.
- Software write accepted at edge t → visible on `ip_o` after t.
- Claim at cycle t → `ip_o[n]` low from t+1, unless an event occurs in cycle t.
- Edge events closer together than one cycle after synchronization merge into one pending. Pending is a flag, not a counter.
- Reset asserted mid-operation: all state clears asynchronously, and pending events are lost. After release, the first edge is detected `SyncStages + 1` cycles after the input transition.
- No combinational path from `claim_i`, `ip_we_i` or `intr_src_i` to `ip_o`.

## Structure
- `clic_pkg` holds:
  - the `trig_t` typedef (2-bit packed);
  - constants `TrigEdgeBit = 0` and `TrigNegBit = 1`.
  The arbiter config register file uses the same package.
- Sub-module `clic_gateway_cell` covers one source: synchronizer via the common_cells `sync`, edge detect, and the `ip_q` flop. It is instantiated `N_SOURCE` times in a generate loop. The top decodes `ip_widx_i` into a per-cell write-enable.

## Test plan
- Level, positive, `SyncStages = 2`: `intr_src_i[5]` rises at cycle 10 → `ip_o[5] = 1` at cycle 13. Line falls at 20 → 0 at 23. `claim_i[5]` at 15 has no effect.
- Edge, positive: a 1-cycle pulse on source 7 → `ip_o[7]` stays 1 until `claim_i[7]`, then 0 on the next cycle. A second pulse re-sets it.
- Edge, negative: idle-high line on source 3 after reset → no pending. A falling transition → pending after 3 cycles. Rising → no change.
- Simultaneous: edge event on source 9 coinciding with `claim_i[9]` → `ip_o[9]` remains 1. Event coinciding with a software write of 0 → remains 1.
- Software: write 1 to index 12 (edge mode) → `ip_o[12] = 1` next cycle. Write 0 → cleared. Write 1 to index 12 in level mode → ignored. Write to index `N_SOURCE` → no bit changes.
- Reset mid-operation: sources 1 and 4 pending, assert `rst_ni` → `ip_o = 0` immediately. After release, a held-high line on source 1 in edge mode yields exactly one pending.

Source files
------------

// File: rtl/clic_pkg.sv
// Shared CLIC definitions: per-source trigger configuration encoding.
// Also imported by the arbiter configuration register file.
package clic_pkg;

    // Per-source trigger configuration.
    // Bit 0 selects edge mode. Bit 1 selects negative polarity.
    typedef logic [1:0] trig_t;

    localparam int unsigned TrigEdgeBit = 0;
    localparam int unsigned TrigNegBit  = 1;

endpackage : clic_pkg

// File: rtl/clic_gateway_cell.sv
// One interrupt source: input synchronizer, polarity/edge detection, pending flop.
module clic_gateway_cell
    import clic_pkg::*;
#(
    parameter int unsigned SyncStages = 2
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  intr_src_i,
    input  trig_t trig_i,
    input  logic  ip_we_i,
    input  logic  ip_wdata_i,
    input  logic  claim_i,
    output logic  ip_o
);

    logic s_s;
    logic prev_r;
    logic ip_r;
    logic act_s;
    logic edge_evt_s;
    logic ip_d_s;

    if (SyncStages == 0) begin : g_no_sync
        // The source already lives in the clk_i domain.
        assign s_s = intr_src_i;
    end else begin : g_sync
        logic [SyncStages-1:0] sync_r;

        // Multi-flop synchronizer chain. Every stage resets to 0.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_r <= '0;
            end else begin
                sync_r[0] <= intr_src_i;
                for (int i = 1; i < int'(SyncStages); i++) begin
                    sync_r[i] <= sync_r[i-1];
                end
            end
        end

        assign s_s = sync_r[SyncStages-1];
    end

    // Track the raw synchronized value, not the active level.
    // An idle-high line then yields one rising event after reset and no falling event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= s_s;
        end
    end

    // Active level and polarity-selected edge event, followed by the pending next state.
    // In edge mode the event outranks software writes and claims, so no edge is lost.
    always_comb begin
        act_s      = s_s ^ trig_i[TrigNegBit];
        edge_evt_s = 1'b0;
        ip_d_s     = ip_r;
        if (trig_i[TrigNegBit]) begin
            edge_evt_s = ~s_s & prev_r;
        end else begin
            edge_evt_s = s_s & ~prev_r;
        end
        if (!trig_i[TrigEdgeBit]) begin
            ip_d_s = act_s;
        end else if (edge_evt_s) begin
            ip_d_s = 1'b1;
        end else if (ip_we_i && ip_wdata_i) begin
            ip_d_s = 1'b1;
        end else if (ip_we_i || claim_i) begin
            ip_d_s = 1'b0;
        end else begin
            ip_d_s = ip_r;
        end
    end

    // Pending flag register. It drives ip_o directly, so nothing reaches ip_o combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_r <= 1'b0;
        end else begin
            ip_r <= ip_d_s;
        end
    end

    assign ip_o = ip_r;

endmodule : clic_gateway_cell

// File: rtl/clic_gateway.sv
// Interrupt gateway in front of the CLIC arbiter.
// It holds one gateway cell per source and decodes the single software IP write port.
module clic_gateway
    import clic_pkg::*;
#(
    parameter int unsigned N_SOURCE   = 256,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned SrcWidth   = $clog2(N_SOURCE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_SOURCE-1:0]   intr_src_i,
    input  trig_t [N_SOURCE-1:0]  trig_i,
    input  logic                  ip_we_i,
    input  logic [SrcWidth-1:0]   ip_widx_i,
    input  logic                  ip_wdata_i,
    input  logic [N_SOURCE-1:0]   claim_i,
    output logic [N_SOURCE-1:0]   ip_o,
    output logic [N_SOURCE-1:0]   le_o
);

    logic [N_SOURCE-1:0] we_s;

    for (genvar n = 0; n < int'(N_SOURCE); n++) begin : g_src
        // An index at or above N_SOURCE matches no cell, so that write is dropped.
        assign we_s[n] = ip_we_i && (ip_widx_i == SrcWidth'(n));
        assign le_o[n] = trig_i[n][TrigEdgeBit];

        clic_gateway_cell #(
            .SyncStages (SyncStages)
        ) u_cell (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .intr_src_i (intr_src_i[n]),
            .trig_i     (trig_i[n]),
            .ip_we_i    (we_s[n]),
            .ip_wdata_i (ip_wdata_i),
            .claim_i    (claim_i[n]),
            .ip_o       (ip_o[n])
        );
    end

endmodule : clic_gateway

// File: tb/tb_clic_gateway.sv
// Directed self-checking bench for clic_gateway. It uses 20 sources, so an
// out-of-range write index can be driven.
module tb_clic_gateway;
    import clic_pkg::*;

    localparam int unsigned NS = 20;
    localparam int unsigned SW = $clog2(NS);

    logic              clk;
    logic              rst_n;
    logic [NS-1:0]     src;
    trig_t [NS-1:0]    trig;
    logic              we;
    logic [SW-1:0]     widx;
    logic              wdata;
    logic [NS-1:0]     claim;
    logic [NS-1:0]     ip;
    logic [NS-1:0]     le;

    int total_cnt;
    int bad_cnt;

    clic_gateway #(
        .N_SOURCE   (NS),
        .SyncStages (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .intr_src_i (src),
        .trig_i     (trig),
        .ip_we_i    (we),
        .ip_widx_i  (widx),
        .ip_wdata_i (wdata),
        .claim_i    (claim),
        .ip_o       (ip),
        .le_o       (le)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance by n clock edges. Inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sw_write(input logic [SW-1:0] idx, input logic d);
        we    = 1'b1;
        widx  = idx;
        wdata = d;
        tick(1);
        we    = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n = 1'b0;
        src   = '0;
        trig  = '0;
        we    = 1'b0;
        widx  = '0;
        wdata = 1'b0;
        claim = '0;
        trig[1]  = 2'b01;
        trig[3]  = 2'b11;
        trig[4]  = 2'b01;
        trig[7]  = 2'b01;
        trig[9]  = 2'b01;
        trig[12] = 2'b01;
        trig[19] = 2'b01;
        src[3]   = 1'b1;
        #3;
        check_eq("reset_ip", 32'(ip), 32'h0);
        check_eq("reset_le", 32'(le), 32'h8129A);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check_eq("idle_high_neg_no_pend", 32'(ip), 32'h0);

        // Level mode, positive polarity, source 5.
        src[5] = 1'b1;
        tick(2);
        check_eq("lvl5_rise_early", 32'(ip[5]), 32'h0);
        tick(1);
        check_eq("lvl5_rise_lat3", 32'(ip[5]), 32'h1);
        claim[5] = 1'b1;
        tick(1);
        claim[5] = 1'b0;
        check_eq("lvl5_claim_ignored", 32'(ip[5]), 32'h1);
        src[5] = 1'b0;
        tick(2);
        check_eq("lvl5_fall_early", 32'(ip[5]), 32'h1);
        tick(1);
        check_eq("lvl5_fall_lat3", 32'(ip[5]), 32'h0);

        // Edge mode, positive polarity, 1-cycle pulse on source 7.
        src[7] = 1'b1;
        tick(1);
        src[7] = 1'b0;
        tick(1);
        check_eq("edge7_early", 32'(ip[7]), 32'h0);
        tick(1);
        check_eq("edge7_set", 32'(ip[7]), 32'h1);
        tick(5);
        check_eq("edge7_hold", 32'(ip[7]), 32'h1);
        claim[7] = 1'b1;
        tick(1);
        claim[7] = 1'b0;
        check_eq("edge7_claimed", 32'(ip[7]), 32'h0);
        src[7] = 1'b1;
        tick(1);
        src[7] = 1'b0;
        tick(2);
        check_eq("edge7_reset_again", 32'(ip[7]), 32'h1);

        // Edge mode, negative polarity, source 3 (idle high).
        src[3] = 1'b0;
        tick(2);
        check_eq("neg3_early", 32'(ip[3]), 32'h0);
        tick(1);
        check_eq("neg3_fall_set", 32'(ip[3]), 32'h1);
        src[3] = 1'b1;
        tick(4);
        check_eq("neg3_rise_nochg", 32'(ip[3]), 32'h1);

        // Edge event on source 9 in the same cycle as its claim.
        src[9] = 1'b1;
        tick(2);
        claim[9] = 1'b1;
        tick(1);
        claim[9] = 1'b0;
        check_eq("evt9_vs_claim", 32'(ip[9]), 32'h1);
        claim[9] = 1'b1;
        tick(1);
        claim[9] = 1'b0;
        check_eq("claim9_clear", 32'(ip[9]), 32'h0);
        src[9] = 1'b0;
        tick(4);
        src[9] = 1'b1;
        tick(2);
        sw_write(SW'(9), 1'b0);
        check_eq("evt9_vs_wr0", 32'(ip[9]), 32'h1);
        sw_write(SW'(9), 1'b0);
        check_eq("wr0_9_clear", 32'(ip[9]), 32'h0);

        // Software writes to source 12.
        sw_write(SW'(12), 1'b1);
        check_eq("wr1_12", 32'(ip[12]), 32'h1);
        sw_write(SW'(12), 1'b0);
        check_eq("wr0_12", 32'(ip[12]), 32'h0);
        trig[12] = 2'b00;
        sw_write(SW'(12), 1'b1);
        check_eq("wr1_12_level_ign", 32'(ip[12]), 32'h0);
        sw_write(SW'(20), 1'b1);
        tick(1);
        check_eq("wr_oob_nochg", 32'(ip), 32'h00088);

        // Multi-hot claim acts on each source independently.
        claim[3] = 1'b1;
        claim[7] = 1'b1;
        tick(1);
        claim = '0;
        check_eq("multi_claim", 32'(ip), 32'h0);

        // Reset mid-operation.
        src[9] = 1'b0;
        tick(4);
        sw_write(SW'(1), 1'b1);
        sw_write(SW'(4), 1'b1);
        check_eq("pre_rst_pend", 32'(ip), 32'h00012);
        src[1] = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_eq("async_rst_clear", 32'(ip), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check_eq("post_rst_early", 32'(ip[1]), 32'h0);
        tick(1);
        check_eq("post_rst_edge1", 32'(ip[1]), 32'h1);
        tick(5);
        check_eq("post_rst_single", 32'(ip), 32'h00002);
        claim[1] = 1'b1;
        tick(1);
        claim[1] = 1'b0;
        tick(5);
        check_eq("post_rst_no_repeat", 32'(ip), 32'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_clic_gateway
